palette_ram_ctrl: RTL and testbench

- Owns a 64x15 custom palette RAM and shares its single port between two requesters: the per-pixel colour lookup from the video path, and a byte-stream palette upload from the HPS download channel.
- Upload data is 64 RGB888 triplets (192 bytes). Each triplet is packed to RGB555 with {B,G,R} bit order, matching the built-in palette tables.
- Sits beside the built-in palette LUTs. Downstream selects this block's output when custom_valid=1.

---
 rtl/palette_ram_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_palette_ram_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_ram_ctrl.sv
// palette_ram_ctrl: 64x15 custom palette RAM shared between the per-pixel
// colour lookup (always has priority) and a 192-byte RGB888 upload stream.
// Optional build macro PALETTE_CLEAR_EN adds a post-reset CLEAR sweep that
// zeroes every entry before uploads are accepted.
module palette_ram_ctrl #(
  parameter int unsigned ENTRIES    = 64,
  parameter int unsigned FILE_BYTES = 192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic [5:0]  color,
  output logic [14:0] pixel,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        custom_valid,
  output logic        busy
);

`ifdef PALETTE_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FINISH, S_CLEAR} state_t;
  localparam state_t RESET_STATE = S_CLEAR;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FINISH} state_t;
  localparam state_t RESET_STATE = S_IDLE;
`endif

  localparam logic [7:0] FILE_BYTES_W = 8'(FILE_BYTES);

  logic [14:0] mem [ENTRIES];

  state_t      state_q, state_d;
  logic        dl_q, dl_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [5:0]  waddr_q, waddr_d;
  logic [4:0]  r_q, r_d;
  logic [4:0]  g_q, g_d;
  logic        pend_q, pend_d;
  logic [5:0]  pend_addr_q, pend_addr_d;
  logic [14:0] pend_data_q, pend_data_d;
  logic        cv_q, cv_d;
  logic [14:0] pixel_q, pixel_d;
`ifdef PALETTE_CLEAR_EN
  logic [5:0]  clr_addr_q, clr_addr_d;
  logic        rise_lat_q, rise_lat_d;
`endif

  logic        rise;
  logic        load_start;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [14:0] mem_wdata;
  logic        unused_low_bits;

  assign rise            = ioctl_download & ~dl_q;
  assign unused_low_bits = ^ioctl_dout[2:0];

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      dl_q        <= 1'b0;
      bcnt_q      <= '0;
      phase_q     <= '0;
      waddr_q     <= '0;
      r_q         <= '0;
      g_q         <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      cv_q        <= 1'b0;
      pixel_q     <= '0;
`ifdef PALETTE_CLEAR_EN
      clr_addr_q  <= '0;
      rise_lat_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dl_q        <= dl_d;
      bcnt_q      <= bcnt_d;
      phase_q     <= phase_d;
      waddr_q     <= waddr_d;
      r_q         <= r_d;
      g_q         <= g_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      cv_q        <= cv_d;
      pixel_q     <= pixel_d;
`ifdef PALETTE_CLEAR_EN
      clr_addr_q  <= clr_addr_d;
      rise_lat_q  <= rise_lat_d;
`endif
    end
  end

  // Palette RAM write port (no reset: contents are only trusted after upload)
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef PALETTE_CLEAR_EN
      S_IDLE:   if (rise || rise_lat_q) state_d = S_LOAD;
      S_CLEAR:  if (!pix_ce && clr_addr_q == 6'(ENTRIES - 1)) state_d = S_IDLE;
`else
      S_IDLE:   if (rise) state_d = S_LOAD;
`endif
      // Level test on ioctl_download covers both the falling edge and
      // holding in LOAD until a pending write has retired.
      S_LOAD:   if (!rise && !ioctl_download && !pend_q) state_d = S_FINISH;
      S_FINISH: state_d = rise ? S_LOAD : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: byte assembly, write arbitration, lookup, validation
  always_comb begin
    dl_d        = ioctl_download;
    bcnt_d      = bcnt_q;
    phase_d     = phase_q;
    waddr_d     = waddr_q;
    r_d         = r_q;
    g_d         = g_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    cv_d        = cv_q;
    pixel_d     = pix_ce ? mem[color] : pixel_q;
    mem_we      = 1'b0;
    mem_addr    = pend_addr_q;
    mem_wdata   = pend_data_q;
`ifdef PALETTE_CLEAR_EN
    clr_addr_d  = clr_addr_q;
    rise_lat_d  = rise_lat_q;
`endif

    // Entry into LOAD, including restart while already loading/finishing
    load_start = (state_d == S_LOAD) && ((state_q != S_LOAD) || rise);

    if (state_q == S_FINISH)
      cv_d = (bcnt_q == FILE_BYTES_W) && !pend_q;

    if (pend_q && !pix_ce) begin
      mem_we = 1'b1;
      pend_d = 1'b0;
    end

    if (load_start) begin
      bcnt_d  = '0;
      phase_d = '0;
      waddr_d = '0;
      cv_d    = 1'b0;
    end else if (state_q == S_LOAD && ioctl_wr && !pend_q && bcnt_q < FILE_BYTES_W) begin
      bcnt_d = bcnt_q + 8'd1;
      case (phase_q)
        2'd0: begin
          r_d     = ioctl_dout[7:3];
          phase_d = 2'd1;
        end
        2'd1: begin
          g_d     = ioctl_dout[7:3];
          phase_d = 2'd2;
        end
        default: begin
          phase_d = 2'd0;
          waddr_d = waddr_q + 6'd1;
          if (!pix_ce) begin
            mem_we    = 1'b1;
            mem_addr  = waddr_q;
            mem_wdata = {ioctl_dout[7:3], g_q, r_q};
          end else begin
            pend_d      = 1'b1;
            pend_addr_d = waddr_q;
            pend_data_d = {ioctl_dout[7:3], g_q, r_q};
          end
        end
      endcase
    end

`ifdef PALETTE_CLEAR_EN
    if (state_q == S_CLEAR) begin
      if (rise) rise_lat_d = 1'b1;
      if (!pix_ce) begin
        mem_we     = 1'b1;
        mem_addr   = clr_addr_q;
        mem_wdata  = '0;
        clr_addr_d = clr_addr_q + 6'd1;
      end
    end
    if (state_q == S_IDLE && state_d == S_LOAD) rise_lat_d = 1'b0;
`endif
  end

  // FSM outputs
  always_comb begin
    busy         = (state_q != S_IDLE);
    custom_valid = cv_q;
    pixel        = pixel_q;
`ifdef PALETTE_CLEAR_EN
    ioctl_wait   = pend_q || (state_q == S_CLEAR);
`else
    ioctl_wait   = pend_q;
`endif
  end

endmodule

// File: tb/tb_palette_ram_ctrl.sv
// Self-checking bench for palette_ram_ctrl: randomized uploads checked
// against a transaction-level palette model built from the uploaded bytes.
module tb_palette_ram_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_ce;
  logic [5:0]  color;
  logic [14:0] pixel;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        custom_valid;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [14:0] model_ram [64];
  logic [7:0]  ubytes [$];

  always #5 clk = ~clk;

  palette_ram_ctrl #(.ENTRIES(64), .FILE_BYTES(192)) dut (
    .clk            (clk),
    .reset          (reset),
    .pix_ce         (pix_ce),
    .color          (color),
    .pixel          (pixel),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .custom_valid   (custom_valid),
    .busy           (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] pack(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {b[7:3], g[7:3], r[7:3]};
  endfunction

  function automatic logic [7:0] pat_byte(input int unsigned i);
    int unsigned n;
    n = i / 3;
    case (i % 3)
      0:       return 8'(8 * n);
      1:       return 8'(255 - 4 * n);
      default: return 8'(4 * n);
    endcase
  endfunction

  // Source side of the upload: honours ioctl_wait before every strobe
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int unsigned guard;
    guard = 0;
    while (ioctl_wait && guard < 500) begin
      pix_ce = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      guard++;
    end
    if (ioctl_wait) check_eq("wait_bound", 32'(ioctl_wait), 32'd0);
    ioctl_wr   = 1'b1;
    ioctl_dout = b;
    pix_ce     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    ioctl_wr = 1'b0;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        pix_ce = 1'($urandom_range(0, 1));
        tick();
      end
    end
    pix_ce = 1'b0;
  endtask

  task automatic upload(input int unsigned n, input bit pattern, input bit rnd, input bit raise);
    logic [7:0] b;
    ubytes.delete();
    if (raise) begin
      ioctl_download = 1'b1;
      tick();
    end
    for (int unsigned i = 0; i < n; i++) begin
      b = pattern ? pat_byte(i) : 8'($urandom_range(0, 255));
      ubytes.push_back(b);
      send_byte(b, rnd);
    end
  endtask

  // Drain any pending write, drop download and check the FINISH/IDLE sequence
  task automatic finish_upload(input bit exp_valid, input string tag);
    int unsigned guard;
    guard  = 0;
    pix_ce = 1'b0;
    while (ioctl_wait && guard < 10) begin
      tick();
      guard++;
    end
    ioctl_download = 1'b0;
    tick();
    check_eq({tag, "_fin_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_fin_cv"}, 32'(custom_valid), 32'd0);
    tick();
    check_eq({tag, "_cv"}, 32'(custom_valid), 32'(exp_valid));
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    if (exp_valid)
      for (int unsigned k = 0; k < 64; k++)
        model_ram[k] = pack(ubytes[3*k], ubytes[3*k+1], ubytes[3*k+2]);
  endtask

  task automatic lookup(input logic [5:0] idx, input string tag);
    pix_ce = 1'b1;
    color  = idx;
    tick();
    pix_ce = 1'b0;
    check_eq(tag, 32'(pixel), 32'(model_ram[idx]));
    color = idx ^ 6'h2A;
    tick();
    check_eq({tag, "_hold"}, 32'(pixel), 32'(model_ram[idx]));
  endtask

  // Runs the post-reset CLEAR sweep to completion (no-op without the macro)
  task automatic wait_clear_done(input string tag);
    int unsigned guard;
    guard = 0;
    while (busy && guard < 2000) begin
      pix_ce = (guard % 8 == 0);
      tick();
      guard++;
    end
    pix_ce = 1'b0;
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b0, b1, b2;
    logic [5:0]  idx;
    int unsigned busy_cnt;
    bit          exp_clr;

`ifdef PALETTE_CLEAR_EN
    exp_clr = 1'b1;
`else
    exp_clr = 1'b0;
`endif
    reset = 1'b1; pix_ce = 1'b0; color = '0;
    ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_dout = '0;
    repeat (3) tick();
    check_eq("rst_pixel", 32'(pixel), 32'd0);
    check_eq("rst_wait", 32'(ioctl_wait), 32'(exp_clr));
    check_eq("rst_cv", 32'(custom_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'(exp_clr));
    reset = 1'b0;

`ifdef PALETTE_CLEAR_EN
    busy_cnt = 0;
    for (int unsigned i = 0; i < 2000 && busy; i++) begin
      pix_ce = (i % 8 == 0);
      if (i == 20) begin
        check_eq("clr_wait", 32'(ioctl_wait), 32'd1);
        check_eq("clr_cv", 32'(custom_valid), 32'd0);
      end
      tick();
      busy_cnt++;
    end
    pix_ce = 1'b0;
    check_eq("clr_len", 32'(busy_cnt >= 64), 32'd1);
    for (int unsigned k = 0; k < 64; k++) model_ram[k] = '0;
    for (int unsigned k = 0; k < 64; k++) lookup(6'(k), "clr_zero");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      pix_ce = (i % 8 == 0);
      tick();
    end
    ioctl_download = 1'b1;
    wait_clear_done("clr2_done");
    tick();
    check_eq("clr_dl_accepted", 32'(busy), 32'd1);
    upload(192, 1'b0, 1'b1, 1'b0);
    finish_upload(1'b1, "clr_up");
    for (int unsigned k = 0; k < 8; k++) lookup(6'($urandom_range(0, 63)), "clr_up_lk");
`endif

    // Pattern upload with no lookups competing for the port
    upload(192, 1'b1, 1'b0, 1'b1);
    finish_upload(1'b1, "pat");
    lookup(6'd5, "pat_lk5");
    check_eq("pat_lk5_fields", 32'(pixel), 32'({5'd2, 5'd29, 5'd5}));
    lookup(6'd63, "pat_lk63");
    for (int unsigned k = 0; k < 8; k++) lookup(6'($urandom_range(0, 63)), "pat_lk");

    // Short upload must not validate
    upload(150, 1'b0, 1'b1, 1'b1);
    finish_upload(1'b0, "short");
    check_eq("short_wait", 32'(ioctl_wait), 32'd0);

    // Triplet completes under pix_ce; download drops while the write is pending
    b0 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    ioctl_download = 1'b1;
    tick();
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    ioctl_wr = 1'b1; ioctl_dout = b2; pix_ce = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    check_eq("pend_wait0", 32'(ioctl_wait), 32'd1);
    repeat (3) tick();
    check_eq("pend_wait3", 32'(ioctl_wait), 32'd1);
    check_eq("pend_hold_load", 32'(busy), 32'd1);
    pix_ce = 1'b0;
    tick();
    check_eq("pend_retired", 32'(ioctl_wait), 32'd0);
    check_eq("pend_still_load", 32'(busy), 32'd1);
    tick();
    check_eq("pend_finish", 32'(busy), 32'd1);
    tick();
    check_eq("pend_idle", 32'(busy), 32'd0);
    check_eq("pend_cv", 32'(custom_valid), 32'd0);
    model_ram[0] = pack(b0, b1, b2);
    lookup(6'd0, "pend_lk0");

    // Overlong upload: bytes past 192 are ignored
    upload(200, 1'b0, 1'b1, 1'b1);
    finish_upload(1'b1, "long");
    for (int unsigned k = 0; k < 64; k++) lookup(6'(k), "long_lk");

    // Reset in the middle of an upload, then a clean upload
    ioctl_download = 1'b1;
    tick();
    for (int unsigned i = 0; i < 90; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    reset = 1'b0;
    check_eq("mrst_cv", 32'(custom_valid), 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'(exp_clr));
    check_eq("mrst_wait", 32'(ioctl_wait), 32'(exp_clr));
    wait_clear_done("mrst_clear_done");
    tick();
    upload(192, 1'b0, 1'b1, 1'b1);
    finish_upload(1'b1, "fresh");
    for (int unsigned k = 0; k < 16; k++) begin
      idx = 6'($urandom_range(0, 63));
      lookup(idx, "fresh_lk");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
